lpffir_inv: RTL and testbench

LPFFIR_INV -- requirements
Module: lpffir_inv

---
 rtl/lpffir_pkg.sv | 27 ++
 rtl/lpffir_hist.sv | 67 ++++++
 rtl/lpffir_inv.sv | 152 +++++++++++++++
 tb/tb_lpffir_inv.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpffir_pkg.sv
// -----------------------------------------------------------------------------
// lpffir_pkg -- shared definitions for the moving-sum FIR inverse.
//
// Contents:
//   DW_DEF / TAPS_DEF : default sample width and forward filter length
//   sample_t          : sample type at the default width
//   state_t           : warm-up / running state of the inverse filter
//   ptr_width()       : bit width needed to index a TAPS-entry buffer
// -----------------------------------------------------------------------------
package lpffir_pkg;

    localparam int DW_DEF   = 16;
    localparam int TAPS_DEF = 6;

    typedef logic [DW_DEF-1:0] sample_t;

    typedef enum logic {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_t;

    // At least one bit, so that a single-tap build still has a legal pointer.
    function automatic int ptr_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/lpffir_hist.sv
// -----------------------------------------------------------------------------
// lpffir_hist -- TAPS-entry circular history of recovered samples.
//
// The slot under the write pointer holds x[n-TAPS]; it is read combinationally
// and overwritten with x[n] when a sample is accepted, after which the pointer
// advances (wrapping from TAPS-1 to 0).
//
// Ports:
//   clk_i      in   clock
//   rstn_i     in   asynchronous reset, active-high
//   clr_i      in   synchronous clear of all slots and the pointer
//   wr_en_i    in   write x[n] into the current slot and advance
//   wr_data_i  in   x[n]
//   rd_data_o  out  x[n-TAPS] (current slot contents)
// -----------------------------------------------------------------------------
module lpffir_hist
    import lpffir_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TAPS = TAPS_DEF
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_data_i,
    output logic [DW-1:0] rd_data_o
);

    localparam int PW = ptr_width(TAPS);

    logic [DW-1:0] r_mem [TAPS];
    logic [PW-1:0] r_wr_ptr;

    assign rd_data_o = r_mem[r_wr_ptr];

    // History must be zeroed on reset/clear, so slots are individual
    // resettable registers rather than a RAM.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_slot
            always_ff @(posedge clk_i or posedge rstn_i) begin
                if (rstn_i) begin
                    r_mem[gi] <= '0;
                end else if (clr_i) begin
                    r_mem[gi] <= '0;
                end else if (wr_en_i && (r_wr_ptr == PW'(gi))) begin
                    r_mem[gi] <= wr_data_i;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            r_wr_ptr <= '0;
        end else if (clr_i) begin
            r_wr_ptr <= '0;
        end else if (wr_en_i) begin
            if (r_wr_ptr == PW'(TAPS - 1)) begin
                r_wr_ptr <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lpffir_inv.sv
// -----------------------------------------------------------------------------
// lpffir_inv -- inverse of a TAPS-long moving-sum FIR.
//
// Recovers x[n] = y[n] - y[n-1] + x[n-TAPS] (mod 2^DW) from the forward
// filter output, with a one-entry output register (latency 1) and
// pass-through ready.
//
// Ports:
//   clk_i      in   clock
//   rstn_i     in   asynchronous reset, active-high
//   clr_i      in   synchronous restart (wins over a simultaneous accept)
//   y_valid_i  in   filtered sample valid
//   y_ready_o  out  filtered sample accepted
//   y_i        in   filtered sample
//   x_valid_o  out  recovered sample valid
//   x_ready_i  in   downstream ready
//   x_o        out  recovered sample
//   primed_o   out  TAPS samples consumed since reset/clear
//   cnt_o      out  completed output handshakes, saturating
//                   (only when LPFFIR_INV_STATS_EN is defined)
//
// Build option: define LPFFIR_INV_STATS_EN to add the cnt_o handshake counter.
// -----------------------------------------------------------------------------
module lpffir_inv
    import lpffir_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int TAPS = TAPS_DEF
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          clr_i,
    input  logic          y_valid_i,
    output logic          y_ready_o,
    input  logic [DW-1:0] y_i,
    output logic          x_valid_o,
    input  logic          x_ready_i,
    output logic [DW-1:0] x_o,
    output logic          primed_o
`ifdef LPFFIR_INV_STATS_EN
    ,
    output logic [15:0]   cnt_o
`endif
);

    localparam int PW = ptr_width(TAPS);

    logic          r_x_valid;
    logic [DW-1:0] r_x;
    logic [DW-1:0] r_y_prev;
    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_warm_cnt;
    logic [PW-1:0] w_warm_cnt_next;

    logic          w_accept;
    logic [DW-1:0] w_hist_rd;
    logic [DW-1:0] w_x_new;

    assign y_ready_o = !r_x_valid || x_ready_i;
    // A clear in the same cycle discards the offered sample.
    assign w_accept  = y_valid_i && y_ready_o && !clr_i;
    // Modulo arithmetic: carries/borrows beyond DW bits are dropped.
    assign w_x_new   = y_i - r_y_prev + w_hist_rd;

    assign x_valid_o = r_x_valid;
    assign x_o       = r_x;
    assign primed_o  = (r_state == RUN);

    lpffir_hist #(
        .DW   (DW),
        .TAPS (TAPS)
    ) u_hist (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clr_i     (clr_i),
        .wr_en_i   (w_accept),
        .wr_data_i (w_x_new),
        .rd_data_o (w_hist_rd)
    );

    // Output register and previous-input register.
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            r_x_valid <= 1'b0;
            r_x       <= '0;
            r_y_prev  <= '0;
        end else if (clr_i) begin
            r_x_valid <= 1'b0;
            r_x       <= '0;
            r_y_prev  <= '0;
        end else if (w_accept) begin
            r_x_valid <= 1'b1;
            r_x       <= w_x_new;
            r_y_prev  <= y_i;
        end else if (r_x_valid && x_ready_i) begin
            r_x_valid <= 1'b0;
        end
    end

    // Warm-up FSM: state register.
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            r_state    <= WARM;
            r_warm_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_warm_cnt <= w_warm_cnt_next;
        end
    end

    // Warm-up FSM: next state. RUN is held until reset or clear.
    always_comb begin
        w_state_next    = r_state;
        w_warm_cnt_next = r_warm_cnt;
        if (clr_i) begin
            w_state_next    = WARM;
            w_warm_cnt_next = '0;
        end else begin
            case (r_state)
                WARM: begin
                    if (w_accept) begin
                        if (r_warm_cnt == PW'(TAPS - 1)) begin
                            w_state_next = RUN;
                        end else begin
                            w_warm_cnt_next = r_warm_cnt + 1'b1;
                        end
                    end
                end
                RUN:     w_state_next = RUN;
                default: w_state_next = WARM;
            endcase
        end
    end

`ifdef LPFFIR_INV_STATS_EN
    logic [15:0] r_cnt;

    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (r_x_valid && x_ready_i && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign cnt_o = r_cnt;
`endif

endmodule

// File: tb/tb_lpffir_inv.sv
module tb_lpffir_inv;
    import lpffir_pkg::*;

    localparam int DW   = 16;
    localparam int TAPS = 6;

    logic          clk_i     = 1'b0;
    logic          rstn_i    = 1'b1;
    logic          clr_i     = 1'b0;
    logic          y_valid_i = 1'b0;
    logic          y_ready_o;
    logic [DW-1:0] y_i       = '0;
    logic          x_valid_o;
    logic          x_ready_i;
    logic [DW-1:0] x_o;
    logic          primed_o;
`ifdef LPFFIR_INV_STATS_EN
    logic [15:0]   cnt_o;
`endif

    int      n_pass  = 0;
    int      n_total = 0;
    sample_t exp_q[$];
    logic    stall_en = 1'b0;
    logic    xr_force = 1'b1;

    lpffir_inv #(
        .DW   (DW),
        .TAPS (TAPS)
    ) dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clr_i     (clr_i),
        .y_valid_i (y_valid_i),
        .y_ready_o (y_ready_o),
        .y_i       (y_i),
        .x_valid_o (x_valid_o),
        .x_ready_i (x_ready_i),
        .x_o       (x_o),
        .primed_o  (primed_o)
`ifdef LPFFIR_INV_STATS_EN
        ,
        .cnt_o     (cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Sole driver of x_ready_i: forced level or random stalls.
    initial begin
        x_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            x_ready_i = stall_en ? ($urandom_range(0, 3) != 0) : xr_force;
        end
    end

    // Monitor: pops the scoreboard on every output handshake, and checks that
    // a stalled output stays put.
    initial begin
        logic          stalled;
        logic [DW-1:0] held;
        sample_t       e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk_i);
            if (rstn_i) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(x_valid_o), 32'd1);
                    check("hold_data", 32'(x_o), 32'(held));
                end
                if (x_valid_o && x_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_out: got 0x%0h, expected no output", x_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("x_o", 32'(x_o), 32'(e));
                        $display("out x_o=0x%04h expected=0x%04h", x_o, e);
                    end
                end
                stalled = x_valid_o && !x_ready_i;
                held    = x_o;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end at 1 time unit after a rising edge.
    task automatic send(input logic [DW-1:0] y, input logic [DW-1:0] e);
        bit done;
        done      = 1'b0;
        y_valid_i = 1'b1;
        y_i       = y;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk_i);
            if (y_ready_o) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk_i);
            #1;
        end
        y_valid_i = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL send_timeout: y=0x%0h accepted=0, required=1", y);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            @(posedge clk_i);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: pending=%0d, required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_clr();
        clr_i = 1'b1;
        @(posedge clk_i);
        #1;
        clr_i = 1'b0;
        check("clr_primed", 32'(primed_o), 32'd0);
        check("clr_valid", 32'(x_valid_o), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] imp_y [8];
        logic [DW-1:0] imp_x [8];
        logic [DW-1:0] stp_y [8];
        logic [DW-1:0] fir   [TAPS];
        logic [DW-1:0] xv, yv;

        imp_y = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0};
        imp_x = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        stp_y = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd6, 16'd6};

        // Reset state.
        #1;
        check("rst_valid", 32'(x_valid_o), 32'd0);
        check("rst_x", 32'(x_o), 32'd0);
        check("rst_primed", 32'(primed_o), 32'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_ready", 32'(y_ready_o), 32'd1);

        // Impulse.
        for (int i = 0; i < 8; i++) begin
            send(imp_y[i], imp_x[i]);
            if (i == 4) check("primed_early", 32'(primed_o), 32'd0);
            if (i == 5) check("primed_6th", 32'(primed_o), 32'd1);
        end
        drain();
        do_clr();

        // Step, then modulo wrap.
        for (int i = 0; i < 8; i++) send(stp_y[i], 16'd1);
        drain();
        do_clr();
        send(16'h0001, 16'h0001);
        send(16'hFFFF, 16'hFFFE);
        drain();
        do_clr();

        // Backpressure.
        xr_force = 1'b0;
        send(16'd10, 16'd10);
        y_valid_i = 1'b1;
        y_i       = 16'd25;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("bp_ready_low", 32'(y_ready_o), 32'd0);
            check("bp_valid_high", 32'(x_valid_o), 32'd1);
            @(posedge clk_i);
            #1;
        end
        xr_force = 1'b1;
        send(16'd25, 16'd15);
        send(16'd30, 16'd5);
        drain();
        do_clr();

        // Clear with a simultaneous valid sample.
        send(16'd1, 16'd1);
        send(16'd2, 16'd1);
        send(16'd3, 16'd1);
        send(16'd4, 16'd1);
        clr_i     = 1'b1;
        y_valid_i = 1'b1;
        y_i       = 16'd99;
        @(posedge clk_i);
        #1;
        clr_i     = 1'b0;
        y_valid_i = 1'b0;
        check("clr_drop_primed", 32'(primed_o), 32'd0);
        check("clr_drop_valid", 32'(x_valid_o), 32'd0);
        send(16'd5, 16'd5);
        drain();

        // Mid-stream reset with a pending output (history: y_prev=5, slot=0).
        xr_force = 1'b0;
        send(16'd7, 16'd2);
        #2;
        rstn_i = 1'b1;
        #1;
        check("mid_rst_valid", 32'(x_valid_o), 32'd0);
        check("mid_rst_x", 32'(x_o), 32'd0);
        check("mid_rst_primed", 32'(primed_o), 32'd0);
        exp_q.delete();
        xr_force = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("mid_rst_ready", 32'(y_ready_o), 32'd1);
        send(16'd3, 16'd3);
        send(16'd5, 16'd2);
        drain();

        // Loopback through a forward moving-sum model with random stalls.
        do_clr();
        for (int k = 0; k < TAPS; k++) fir[k] = '0;
        stall_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            xv = DW'($urandom);
            for (int k = TAPS - 1; k > 0; k--) fir[k] = fir[k-1];
            fir[0] = xv;
            yv = '0;
            for (int k = 0; k < TAPS; k++) yv = yv + fir[k];
            send(yv, xv);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i);
                #1;
            end
        end
        stall_en = 1'b0;
        drain();
        @(posedge clk_i);
        #1;
`ifdef LPFFIR_INV_STATS_EN
        check("cnt_o", 32'(cnt_o), 32'd1000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
